// File: rtl/shared_counters_pkg.sv
// Shared types and helpers for the carved subcounter pool.
package shared_counters_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_INC     = 3'b001,
    OP_ALLOC   = 3'b010,
    OP_DEALLOC = 3'b011,
    OP_LOAD    = 3'b100,
    OP_READ    = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_RSVD    = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  // Mask helper works on a fixed-width view; pools up to 64 subcounters.
  localparam int MASK_W  = 64;
  localparam int MASK_AW = 6;

  // Head at id plus following subcounters that are neither free nor a head.
  function automatic logic [MASK_W-1:0] extent_mask(input logic [MASK_W-1:0] head,
                                                    input logic [MASK_W-1:0] free,
                                                    input int id, input int n);
    logic [MASK_W-1:0] m;
    logic run;
    m   = '0;
    run = head[id[MASK_AW-1:0]];
    for (int j = 0; j < MASK_W; j++) begin
      if (j == id) m[j] = run;
      else if (j > id) begin
        run  = run && (j < n) && !free[j] && !head[j];
        m[j] = run;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/counter_first_fit.sv
// Lowest-index search for a run of size_i contiguous free subcounters.
module counter_first_fit #(
  parameter int N_SUB    = 16,
  parameter int MAX_SIZE = 8,
  localparam int IDW = $clog2(N_SUB),
  localparam int SZW = $clog2(MAX_SIZE) + 1
) (
  input  logic [N_SUB-1:0] free_i,
  input  logic [SZW-1:0]   size_i,
  output logic             found_o,
  output logic [IDW-1:0]   idx_o
);

  // Zero padding past the top makes runs that would cross N_SUB fail.
  logic [N_SUB+MAX_SIZE-1:0] pad;
  assign pad = {{MAX_SIZE{1'b0}}, free_i};

  always_comb begin
    logic fit;
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N_SUB - 1; i >= 0; i--) begin
      fit = (size_i != '0);
      for (int k = 0; k < MAX_SIZE; k++)
        if (k < 32'(size_i)) fit = fit && pad[i+k];
      if (fit) begin
        found_o = 1'b1;
        idx_o   = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/shared_counter_pool.sv
// Pool of N_SUB G-bit subcounters carved into variable-size counters by command.
module shared_counter_pool
  import shared_counters_pkg::*;
#(
  parameter int N_SUB    = 16,
  parameter int G        = 4,
  parameter int MAX_SIZE = 8,
  localparam int IDW = $clog2(N_SUB),
  localparam int SZW = $clog2(MAX_SIZE) + 1,
  localparam int CW  = $clog2(N_SUB) + 1,
  localparam int LDW = N_SUB * G
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [2:0]            cmd_op_i,
  input  logic [IDW-1:0]        cmd_id_i,
  input  logic [SZW-1:0]        cmd_size_i,
  input  logic                  cmd_sat_i,
  input  logic [MAX_SIZE*G-1:0] cmd_wdata_i,
  output logic                  resp_valid_o,
  output logic                  resp_err_o,
  output logic                  resp_ovf_o,
  output logic [IDW-1:0]        resp_id_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [G-1:0]          rd_data_o,
  output logic                  rd_last_o,
  output logic [CW-1:0]         free_count_o
);

  logic [N_SUB-1:0][G-1:0] sub_q, sub_d, inc_v;
  logic [N_SUB-1:0]        free_q, free_d, head_q, head_d, sat_q, sat_d;
  logic [N_SUB-1:0]        rd_rem_q, rd_rem_d, ext, amask;
  logic [IDW-1:0]          rd_idx_q, rd_idx_d, resp_id_q, resp_id_d, ff_idx;
  logic [CW-1:0]           free_count_q, free_count_d;
  logic                    resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic                    resp_ovf_q, resp_ovf_d, ff_found, is_head, size_ok, all1;
  logic [LDW-1:0]          ld_vec;
  state_e                  state_q, state_d;
  op_e                     op;

  counter_first_fit #(.N_SUB(N_SUB), .MAX_SIZE(MAX_SIZE)) u_ff (
    .free_i (free_q),
    .size_i (cmd_size_i),
    .found_o(ff_found),
    .idx_o  (ff_idx)
  );

  assign op      = op_e'(cmd_op_i);
  assign is_head = (32'(cmd_id_i) < N_SUB) && head_q[cmd_id_i];
  assign size_ok = (cmd_size_i != '0) && (32'(cmd_size_i) <= MAX_SIZE);
  assign ext     = N_SUB'(extent_mask(MASK_W'(head_q), MASK_W'(free_q), 32'(cmd_id_i), N_SUB));
  assign ld_vec  = LDW'(cmd_wdata_i) << (32'(cmd_id_i) * G);

  // Extent treated as one size*G-bit number, carry rippling from the head.
  always_comb begin
    logic c;
    c     = 1'b1;
    all1  = 1'b1;
    inc_v = sub_q;
    for (int j = 0; j < N_SUB; j++) begin
      amask[j] = (j >= 32'(ff_idx)) && (j < 32'(ff_idx) + 32'(cmd_size_i));
      if (ext[j]) begin
        all1 = all1 & (&sub_q[j]);
        {c, inc_v[j]} = {1'b0, sub_q[j]} + {{G{1'b0}}, c};
      end
    end
  end

  always_comb begin
    sub_d        = sub_q;
    free_d       = free_q;
    head_d       = head_q;
    sat_d        = sat_q;
    state_d      = state_q;
    rd_idx_d     = rd_idx_q;
    rd_rem_d     = rd_rem_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_ovf_d   = 1'b0;
    resp_id_d    = resp_id_q;
    if (state_q == ST_READ) begin
      if (rd_ready_i) begin
        if (rd_last_o) begin
          state_d  = ST_IDLE;
          rd_rem_d = '0;
        end else begin
          rd_idx_d = rd_idx_q + IDW'(1);
          rd_rem_d = rd_rem_q >> 1;
        end
      end
    end else if (cmd_valid_i && op != OP_NOP) begin
      resp_valid_d = 1'b1;
      resp_id_d    = cmd_id_i;
      if (op == OP_ALLOC) begin
        resp_id_d = '0;
        if (size_ok && ff_found) begin
          resp_id_d      = ff_idx;
          head_d[ff_idx] = 1'b1;
          sat_d[ff_idx]  = cmd_sat_i;
          for (int j = 0; j < N_SUB; j++)
            if (amask[j]) begin
              free_d[j] = 1'b0;
              sub_d[j]  = '0;
            end
        end else resp_err_d = 1'b1;
      end else if (op == OP_RSVD || !is_head) begin
        resp_err_d = 1'b1;
      end else begin
        case (op)
          OP_INC: begin
            resp_ovf_d = all1;
            if (!(all1 && sat_q[cmd_id_i]))
              for (int j = 0; j < N_SUB; j++) if (ext[j]) sub_d[j] = inc_v[j];
          end
          OP_DEALLOC: begin
            head_d[cmd_id_i] = 1'b0;
            for (int j = 0; j < N_SUB; j++)
              if (ext[j]) begin
                free_d[j] = 1'b1;
                sub_d[j]  = '0;
              end
          end
          OP_LOAD:
            for (int j = 0; j < N_SUB; j++) if (ext[j]) sub_d[j] = ld_vec[j*G +: G];
          OP_CLEAR:
            for (int j = 0; j < N_SUB; j++) if (ext[j]) sub_d[j] = '0;
          OP_READ: begin
            state_d  = ST_READ;
            rd_idx_d = cmd_id_i;
            rd_rem_d = ext >> (32'(cmd_id_i) + 1);
          end
          default: ;
        endcase
      end
    end
    free_count_d = CW'($countones(free_d));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q        <= '0;
      free_q       <= '1;
      head_q       <= '0;
      sat_q        <= '0;
      state_q      <= ST_IDLE;
      rd_idx_q     <= '0;
      rd_rem_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_ovf_q   <= 1'b0;
      resp_id_q    <= '0;
      free_count_q <= CW'(N_SUB);
    end else begin
      sub_q        <= sub_d;
      free_q       <= free_d;
      head_q       <= head_d;
      sat_q        <= sat_d;
      state_q      <= state_d;
      rd_idx_q     <= rd_idx_d;
      rd_rem_q     <= rd_rem_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_ovf_q   <= resp_ovf_d;
      resp_id_q    <= resp_id_d;
      free_count_q <= free_count_d;
    end
  end

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign rd_valid_o   = (state_q == ST_READ);
  assign rd_data_o    = rd_valid_o ? sub_q[rd_idx_q] : '0;
  assign rd_last_o    = rd_valid_o && !rd_rem_q[0];
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_ovf_o   = resp_ovf_q;
  assign resp_id_o    = resp_id_q;
  assign free_count_o = free_count_q;

endmodule

// File: tb/tb_shared_counter_pool.sv
// Randomized and directed checks of shared_counter_pool against a per-counter value model.
module tb_shared_counter_pool;
  localparam int N = 8, G = 4, MS = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_sat = 1'b0;
  logic [2:0]  cmd_op = '0, cmd_id = '0, cmd_size = '0, resp_id;
  logic [15:0] cmd_wdata = '0;
  logic        resp_valid, resp_err, resp_ovf, rd_valid, rd_ready = 1'b0, rd_last;
  logic [3:0]  rd_data, free_count;

  int tests_run = 0, tests_failed = 0;

  // Model: one integer value per live counter, keyed by head index.
  int m_size[N];
  bit m_sat[N];
  int m_val[N];
  bit m_used[N];
  bit e_err, e_ovf;
  int e_id, e_fc;

  shared_counter_pool #(.N_SUB(N), .G(G), .MAX_SIZE(MS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_id_i(cmd_id), .cmd_size_i(cmd_size), .cmd_sat_i(cmd_sat),
    .cmd_wdata_i(cmd_wdata), .resp_valid_o(resp_valid), .resp_err_o(resp_err),
    .resp_ovf_o(resp_ovf), .resp_id_o(resp_id), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data), .rd_last_o(rd_last), .free_count_o(free_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_size[i] = 0; m_sat[i] = 0; m_val[i] = 0; m_used[i] = 0;
    end
  endfunction

  function automatic void model_cmd(int op, int id, int size, bit sat, int wd);
    int mx;
    e_err = 0; e_ovf = 0; e_id = id;
    mx = (m_size[id] > 0) ? (1 << (G * m_size[id])) - 1 : 0;
    if (op == 2) begin
      e_id = 0; e_err = 1;
      if (size >= 1 && size <= MS)
        for (int h = 0; h + size <= N && e_err; h++) begin
          bit fit;
          fit = 1;
          for (int k = 0; k < size; k++) if (m_used[h+k]) fit = 0;
          if (fit) begin
            e_err = 0; e_id = h;
            m_size[h] = size; m_sat[h] = sat; m_val[h] = 0;
            for (int k = 0; k < size; k++) m_used[h+k] = 1;
          end
        end
    end else if (op == 7) e_err = 1;
    else if (op != 0) begin
      if (m_size[id] == 0) e_err = 1;
      else case (op)
        1: if (m_val[id] == mx) begin
             e_ovf = 1;
             if (!m_sat[id]) m_val[id] = 0;
           end else m_val[id]++;
        3: begin
             for (int k = 0; k < m_size[id]; k++) m_used[id+k] = 0;
             m_size[id] = 0; m_val[id] = 0;
           end
        4: m_val[id] = wd & mx;
        6: m_val[id] = 0;
        default: ;
      endcase
    end
    e_fc = 0;
    for (int i = 0; i < N; i++) if (!m_used[i]) e_fc++;
  endfunction

  task automatic do_cmd(input int op, input int id, input int size, input bit sat, input int wd);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk); w++;
    end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL cmd_ready_wait got=%b want=1", cmd_ready);
    end
    cmd_valid = 1; cmd_op = 3'(op); cmd_id = 3'(id); cmd_size = 3'(size);
    cmd_sat = sat; cmd_wdata = 16'(wd);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_op = '0;
    model_cmd(op, id, size, sat, wd);
  endtask

  // Streams one read with the given ready pattern (bit per cycle; 1 past bit 31) or random ready.
  task automatic run_read(input int h, input bit rnd, input logic [31:0] pat);
    int beat, cyc, n, v;
    bit r, last;
    beat = 0; cyc = 0; n = m_size[h]; v = m_val[h];
    while (beat < n && cyc < 64) begin
      r = rnd ? 1'($urandom_range(0, 1)) : (cyc < 32 ? pat[cyc] : 1'b1);
      rd_ready = r;
      last = (beat == n - 1);
      tests_run++;
      if ({rd_valid, rd_last, rd_data, cmd_ready} !== {1'b1, last, 4'((v >> (G * beat)) & 15), 1'b0}) begin
        tests_failed++;
        $display("FAIL read_beat h=%0d beat=%0d got v/l/d/rdy=%b/%b/%h/%b want 1/%b/%h/0",
                 h, beat, rd_valid, rd_last, rd_data, cmd_ready, last, (v >> (G * beat)) & 15);
      end
      @(posedge clk); #1;
      if (r) beat++;
      cyc++;
    end
    rd_ready = 0;
    tests_run++;
    if (cyc >= 64 || {rd_valid, cmd_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL read_end h=%0d cyc=%0d got valid/ready=%b/%b want 0/1", h, cyc, rd_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({cmd_ready, resp_valid, resp_err, resp_ovf, resp_id, rd_valid, rd_data, rd_last, free_count}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 4'd8}) begin
      tests_failed++;
      $display("FAIL reset_state got rdy=%b rv=%b err=%b ovf=%b id=%0d rv=%b rd=%h rl=%b fc=%0d want 1 0 0 0 0 0 0 0 8",
               cmd_ready, resp_valid, resp_err, resp_ovf, resp_id, rd_valid, rd_data, rd_last, free_count);
    end
  endtask

  task automatic test_alloc();
    do_cmd(2, 0, 2, 0, 0);
    tests_run++;
    if ({resp_valid, resp_err, resp_id, free_count} !== {1'b1, 1'b0, 3'd0, 4'd6}) begin
      tests_failed++;
      $display("FAIL alloc2 got v=%b e=%b id=%0d fc=%0d want 1 0 0 6", resp_valid, resp_err, resp_id, free_count);
    end
    do_cmd(2, 0, 3, 1, 0);
    tests_run++;
    if ({resp_valid, resp_err, resp_id, free_count} !== {1'b1, 1'b0, 3'd2, 4'd3}) begin
      tests_failed++;
      $display("FAIL alloc3 got v=%b e=%b id=%0d fc=%0d want 1 0 2 3", resp_valid, resp_err, resp_id, free_count);
    end
  endtask

  task automatic test_inc_wrap_sat();
    do_cmd(4, 0, 0, 0, 'h0FF);
    do_cmd(1, 0, 0, 0, 0);
    tests_run++;
    if ({resp_valid, resp_err, resp_ovf} !== 3'b101) begin
      tests_failed++;
      $display("FAIL inc_wrap got v/e/ovf=%b%b%b want 101", resp_valid, resp_err, resp_ovf);
    end
    do_cmd(5, 0, 0, 0, 0);
    run_read(0, 0, 32'hFFFF_FFFF);
    do_cmd(4, 2, 0, 0, 'hFFF);
    do_cmd(1, 2, 0, 0, 0);
    tests_run++;
    if ({resp_valid, resp_err, resp_ovf} !== 3'b101 || m_val[2] != 'hFFF) begin
      tests_failed++;
      $display("FAIL inc_sat got v/e/ovf=%b%b%b want 101", resp_valid, resp_err, resp_ovf);
    end
    do_cmd(5, 2, 0, 0, 0);
    run_read(2, 0, 32'hFFFF_FFFF);
  endtask

  task automatic test_dealloc_fit();
    do_cmd(3, 0, 0, 0, 0);
    tests_run++;
    if ({resp_err, free_count} !== {1'b0, 4'd5}) begin
      tests_failed++;
      $display("FAIL dealloc got e=%b fc=%0d want 0 5", resp_err, free_count);
    end
    do_cmd(2, 0, 3, 0, 0);
    tests_run++;
    if ({resp_err, resp_id, free_count} !== {1'b0, 3'd5, 4'd2}) begin
      tests_failed++;
      $display("FAIL refit got e=%b id=%0d fc=%0d want 0 5 2", resp_err, resp_id, free_count);
    end
    do_cmd(2, 0, 5, 0, 0);
    tests_run++;
    if ({resp_valid, resp_err, resp_id, free_count} !== {1'b1, 1'b1, 3'd0, 4'd2}) begin
      tests_failed++;
      $display("FAIL alloc_too_big got v=%b e=%b id=%0d fc=%0d want 1 1 0 2", resp_valid, resp_err, resp_id, free_count);
    end
  endtask

  task automatic test_read_stall();
    do_cmd(4, 2, 0, 0, 'h321);
    do_cmd(5, 2, 0, 0, 0);
    tests_run++;
    if ({resp_valid, resp_err, resp_id} !== {1'b1, 1'b0, 3'd2}) begin
      tests_failed++;
      $display("FAIL read_resp got v=%b e=%b id=%0d want 1 0 2", resp_valid, resp_err, resp_id);
    end
    run_read(2, 0, 32'hFFFF_FFFD);
  endtask

  task automatic test_errors();
    int ops[3] = '{1, 3, 7};
    int ids[3] = '{1, 7, 0};
    for (int i = 0; i < 3; i++) begin
      do_cmd(ops[i], ids[i], 0, 0, 0);
      tests_run++;
      if ({resp_valid, resp_err, resp_ovf, resp_id, free_count} !== {1'b1, 1'b1, 1'b0, 3'(ids[i]), 4'd2}) begin
        tests_failed++;
        $display("FAIL err_op%0d got v=%b e=%b ovf=%b id=%0d fc=%0d want 1 1 0 %0d 2",
                 ops[i], resp_valid, resp_err, resp_ovf, resp_id, free_count, ids[i]);
      end
    end
    do_cmd(5, 2, 0, 0, 0);
    run_read(2, 1, 0);
    do_cmd(5, 5, 0, 0, 0);
    run_read(5, 1, 0);
  endtask

  task automatic test_reset_mid_read();
    do_cmd(4, 5, 0, 0, 'h987);
    do_cmd(5, 5, 0, 0, 0);
    rd_ready = 0;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    model_reset();
    tests_run++;
    if ({rd_valid, rd_last, free_count, cmd_ready, resp_valid} !== {1'b0, 1'b0, 4'd8, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_read got rv=%b rl=%b fc=%0d rdy=%b resp=%b want 0 0 8 1 0",
               rd_valid, rd_last, free_count, cmd_ready, resp_valid);
    end
    @(negedge clk); rst_n = 1;
    do_cmd(5, 2, 0, 0, 0);
    tests_run++;
    if ({resp_valid, resp_err, resp_id} !== {1'b1, 1'b1, 3'd2}) begin
      tests_failed++;
      $display("FAIL read_after_reset got v=%b e=%b id=%0d want 1 1 2", resp_valid, resp_err, resp_id);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({rd_valid, cmd_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL no_stream got rv=%b rdy=%b want 0 1", rd_valid, cmd_ready);
    end
  endtask

  task automatic test_random();
    int r, op, id, size, wd;
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 15));
      op = (r == 0) ? 0 : (r <= 3 || r == 15) ? 1 : (r <= 6) ? 2 : (r <= 8) ? 3 :
           (r <= 10) ? 4 : (r <= 12) ? 5 : (r == 13) ? 6 : 7;
      id = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 9) < 7)
        for (int k = 0; k < N; k++)
          if (m_size[(id + k) % N] != 0) begin
            id = (id + k) % N;
            break;
          end
      size = int'($urandom_range(0, 5));
      wd = $urandom_range(0, 1) ? 'hFFFF : int'($urandom_range(0, 'hFFFF));
      do_cmd(op, id, size, 1'($urandom_range(0, 1)), wd);
      tests_run++;
      if (op == 0) begin
        if ({resp_valid, free_count} !== {1'b0, 4'(e_fc)}) begin
          tests_failed++;
          $display("FAIL rnd_nop it=%0d got v=%b fc=%0d want 0 %0d", it, resp_valid, free_count, e_fc);
        end
      end else if ({resp_valid, resp_err, resp_ovf, resp_id, free_count} !== {1'b1, e_err, e_ovf, 3'(e_id), 4'(e_fc)}) begin
        tests_failed++;
        $display("FAIL rnd_op%0d it=%0d id=%0d got e=%b ovf=%b id=%0d fc=%0d want %b %b %0d %0d",
                 op, it, id, resp_err, resp_ovf, resp_id, free_count, e_err, e_ovf, e_id, e_fc);
      end
      if (op == 5 && !e_err) run_read(id, 1, 0);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    #1;
    test_reset();
    test_alloc();
    test_inc_wrap_sat();
    test_dealloc_fit();
    test_read_stall();
    test_errors();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shared_counter_pool.md
Name: shared_counter_pool

Overview:
- Parametrised successor to the shared subcounter array: a pool of N_SUB G-bit subcounters that software carves into variable-size counters.
- Carving uses a valid/ready command port: allocate (first-fit), deallocate, increment (wrap or saturate, chosen at allocation), clear, load, and streamed read.
- All state is registered. Command responses come back on a separate response channel. Reads stream out on a valid/ready beat channel.
- Sits between the control interface and statistics consumers.

Parameters:
- N_SUB, 16: number of G-bit subcounters in the pool.
- G, 4: bits per subcounter.
- MAX_SIZE, 8: maximum subcounters per counter; must be <= N_SUB.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  000 NOP, 001 INC, 010 ALLOC, 011 DEALLOC, 100 LOAD, 101 READ, 110 CLEAR, 111 reserved.
- cmd_id  in  $clog2(N_SUB)  counter id, which is the index of the head subcounter.
- cmd_size  in  $clog2(MAX_SIZE)+1  ALLOC size in subcounters.
- cmd_sat  in  1  ALLOC mode: 1 = saturate, 0 = wrap.
- cmd_wdata  in  MAX_SIZE*G  LOAD value; least-significant G bits go to the head subcounter.
- resp_valid  out  1  one-cycle pulse per accepted non-NOP command.
- resp_err  out  1  command rejected; no state change.
- resp_ovf  out  1  INC wrapped or hit saturation.
- resp_id  out  $clog2(N_SUB)  allocated id for ALLOC, otherwise echoes cmd_id.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  read beat accepted.
- rd_data  out  G  read beat, least-significant subcounter first.
- rd_last  out  1  marks the final beat of a read.
- free_count  out  $clog2(N_SUB)+1  number of free subcounters.

Behaviour:
- State, all registered:
  - sub_q[N_SUB][G]
  - free_q[N_SUB]
  - head_q[N_SUB]
  - sat_q[N_SUB], meaningful only at head positions.
- Counter extent: head subcounter h plus each following subcounter j > h that is not free and not a head; the extent stops at the first free or head position, or at N_SUB.
- Reset (rst = 0, asynchronous):
  - sub_q = 0, free_q = all 1, head_q = 0, sat_q = 0.
  - FSM = IDLE, cmd_ready = 1, resp_valid = 0, resp_err = 0, resp_ovf = 0, resp_id = 0.
  - rd_valid = 0, rd_data = 0, rd_last = 0, free_count = N_SUB.
  - Reset mid-READ aborts the stream immediately.
- FSM has two states, IDLE and READ:
  - In IDLE, cmd_ready = 1.
  - In READ, cmd_ready = 0.
- Accepted commands in IDLE:
  - All updates are visible next cycle.
  - resp_valid fires on the next cycle (latency 1).
  - NOP produces no response.
- Error rule: id-based commands (INC, DEALLOC, LOAD, READ, CLEAR) on a non-head cmd_id give resp_err = 1. Reserved op gives resp_err = 1.
- ALLOC:
  - Lowest-index first fit of cmd_size contiguous free subcounters.
  - On success: head_q[h] = 1, free bits cleared, allocated subcounters zeroed, sat_q[h] = cmd_sat, resp_id = h.
  - cmd_size == 0, cmd_size > MAX_SIZE, or no fit: resp_err = 1, resp_id = 0.
- DEALLOC: extent subcounters set free and zeroed; head_q[h] = 0.
- INC: +1 across the extent as one binary number of size*G bits, with carry rippling up.
  - If all ones and wrap mode: result 0, resp_ovf = 1.
  - If all ones and saturate mode: value held, resp_ovf = 1.
- CLEAR: zeroes the extent.
- LOAD:
  - Subcounter h+k gets cmd_wdata[k*G +: G] for k < size.
  - Bits beyond the extent are ignored.
- READ:
  - Accepted READ: resp_valid pulses (resp_err = 0) and the FSM enters READ.
  - The first beat is presented the next cycle: rd_valid = 1, rd_data = sub_q[h].
  - A beat advances on rd_valid && rd_ready, with no bubbles between beats.
  - rd_last = 1 on beat size-1.
  - After the last beat is accepted: return to IDLE, rd_valid = 0, cmd_ready = 1 the following cycle.
  - rd_data and rd_last hold stable while rd_valid && !rd_ready.
  - READ on a non-head id: resp_err only; no stream starts.
- free_count is registered and updated in the same cycle as free_q.
- Data width: INC on a counter of the maximum size covers MAX_SIZE*G bits. Allocation never crosses N_SUB.

Decomposition:
- shared_counters_pkg:
  - op enum (NOP, INC, ALLOC, DEALLOC, LOAD, READ, CLEAR).
  - FSM state enum (IDLE, READ).
  - Helper function extent_mask(head_q, free_q, id) returning an N_SUB-bit vector.
- Sub-module counter_first_fit: combinational; inputs free_q and size; outputs found and index; lowest-index contiguous-run search.

Test Plan (N_SUB=8, G=4, MAX_SIZE=4):
- Reset, then ALLOC size 2 sat=0, then ALLOC size 3 sat=1 -> resp_id 0 then 2; free_count 8 -> 6 -> 3.
- LOAD id0 wdata 0x0FF, then INC id0 -> sub0 = 0, sub1 = 0; resp_ovf = 1 (wrap). LOAD id2 0xFFF, then INC -> value held at 0xFFF, resp_ovf = 1.
- DEALLOC id0, then ALLOC size 3 -> fails (only 2 contiguous free at 0..1; 5..7 free gives 3) -> resp_id 5. ALLOC size 5 -> resp_err.
- LOAD id2 0x321, then READ id2 with rd_ready toggling 1,0,1,1 -> beats 1, 2, 3 in order; rd_data held during the stall; rd_last on beat 3; cmd_ready low throughout.
- INC id1 (non-head), DEALLOC id7, op 111 -> resp_err = 1 each; no state change, checked by a following READ.
- Assert rst low in the middle of a READ -> rd_valid = 0 and free_count = 8 asynchronously; a READ of id2 after reset returns resp_err.
